// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game sequencer driving ball movement, scores, serve delay and win detection.
module pong_game_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int DLY_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               paddle_collision,
  input  logic               wall_collision,
  input  logic               p1_miss,
  input  logic               p2_miss,
  output logic               ball_reset,
  output logic               ball_en,
  output logic               ball_dir_x,
  output logic               bounce_x,
  output logic               bounce_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [2:0]         state,
  output logic               game_over,
  output logic [1:0]         winner
);
  typedef enum logic [2:0] {IDLE, SERVE, RALLY, POINT, GAME_OVER} state_t;
  // A zero delay still costs one frame_tick before the serve.
  localparam logic [DLY_W-1:0]   LAST = (SERVE_DELAY == 0) ? '0 : DLY_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
  state_t cur, nxt;
  logic [DLY_W-1:0] cnt, cnt_d;
  logic [SCORE_W-1:0] s1_d, s2_d;
  logic [1:0] win_d;
  logic dir_d, bx_d, by_d, start_q, start_rise;
  assign start_rise = start & ~start_q;
  assign state      = cur;
  assign game_over  = cur == GAME_OVER;
  assign ball_en    = cur == RALLY;
  assign ball_reset = !(cur == RALLY || cur == POINT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= IDLE;
      cnt        <= '0;
      score1     <= '0;
      score2     <= '0;
      winner     <= 2'd0;
      ball_dir_x <= 1'b1;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_d;
      score1     <= s1_d;
      score2     <= s2_d;
      winner     <= win_d;
      ball_dir_x <= dir_d;
      bounce_x   <= bx_d;
      bounce_y   <= by_d;
      start_q    <= start;
    end
  end
  always_comb begin
    nxt   = cur;
    cnt_d = cnt;
    s1_d  = score1;
    s2_d  = score2;
    win_d = winner;
    dir_d = ball_dir_x;
    bx_d  = 1'b0;
    by_d  = 1'b0;
    case (cur)
      IDLE, GAME_OVER: begin
        if (start_rise) begin
          s1_d  = '0;
          s2_d  = '0;
          win_d = 2'd0;
          dir_d = 1'b1;
          nxt   = SERVE;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          cnt_d = (cnt == LAST) ? '0 : cnt + DLY_W'(1);
          nxt   = (cnt == LAST) ? RALLY : SERVE;
        end
      end
      RALLY: begin
        if (p1_miss && p2_miss) nxt = SERVE;
        else if (p1_miss) begin
          s2_d  = (score2 >= WIN) ? WIN : score2 + SCORE_W'(1);
          dir_d = 1'b0;
          nxt   = POINT;
        end else if (p2_miss) begin
          s1_d  = (score1 >= WIN) ? WIN : score1 + SCORE_W'(1);
          dir_d = 1'b1;
          nxt   = POINT;
        end else begin
          bx_d = paddle_collision;
          by_d = wall_collision;
        end
      end
      POINT: begin
        win_d = (score1 == WIN) ? 2'd1 : (score2 == WIN) ? 2'd2 : 2'd0;
        nxt   = (score1 == WIN || score2 == WIN) ? GAME_OVER : SERVE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule
